// File: rtl/snitch_barrier_pkg.sv
// Shared types and sizing helpers for the multi-channel hardware barrier.
package snitch_barrier_pkg;

    typedef enum logic [0:0] {
        BARRIER_WAIT    = 1'b0,
        BARRIER_RELEASE = 1'b1
    } barrier_state_e;

    // Index width for a set of n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/snitch_barrier_multi_channel.sv
// One barrier channel: collects masked arrivals, signals completion and counts generations.
module snitch_barrier_channel
    import snitch_barrier_pkg::*;
#(
    parameter int NrCores  = 8,
    parameter int GenWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NrCores-1:0]  match_i,
    input  logic [NrCores-1:0]  mask_i,
    output logic [NrCores-1:0]  release_o,
    output logic [NrCores-1:0]  arrived_o,
    output logic                idle_o,
    output logic                busy_o,
    output logic [GenWidth-1:0] gen_o
);

    barrier_state_e      state_r, state_s;
    logic [NrCores-1:0]  arrived_r, arrived_s, new_s;
    logic [GenWidth-1:0] gen_r, gen_s;
    logic                busy_r;

    // Next-state: record fresh arrivals in WAIT; on completion clear and count the generation.
    always_comb begin
        state_s   = state_r;
        arrived_s = arrived_r;
        gen_s     = gen_r;
        new_s     = '0;
        release_o = '0;
        case (state_r)
            BARRIER_WAIT: begin
                new_s = match_i & mask_i & ~arrived_r;
                if ((mask_i != '0) && (((arrived_r | new_s) & mask_i) == mask_i)) begin
                    state_s   = BARRIER_RELEASE;
                    arrived_s = '0;
                    gen_s     = gen_r + GenWidth'(1);
                    release_o = mask_i;
                end else begin
                    arrived_s = arrived_r | new_s;
                end
            end
            BARRIER_RELEASE: begin
                state_s = BARRIER_WAIT;
            end
            default: begin
                state_s   = BARRIER_WAIT;
                arrived_s = '0;
            end
        endcase
    end

    // Channel state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= BARRIER_WAIT;
            arrived_r <= '0;
            gen_r     <= '0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            arrived_r <= arrived_s;
            gen_r     <= gen_s;
            busy_r    <= |arrived_s;
        end
    end

    assign arrived_o = arrived_r;
    assign idle_o    = (state_r == BARRIER_WAIT) && (arrived_r == '0);
    assign busy_o    = busy_r;
    assign gen_o     = gen_r;

endmodule

// File: rtl/snitch_barrier_multi.sv
// Cluster barrier unit: NrBarriers maskable channels shared by NrCores cores,
// with per-core release handshake, generation counters and misuse reporting.
module snitch_barrier_multi
    import snitch_barrier_pkg::*;
#(
    parameter int  NrCores    = 8,
    parameter int  NrBarriers = 4,
    parameter int  GenWidth   = 8,
    localparam int IdWidth    = idx_width(NrBarriers),
    localparam int CoreWidth  = idx_width(NrCores)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           cfg_valid_i,
    output logic                           cfg_ready_o,
    input  logic [IdWidth-1:0]             cfg_id_i,
    input  logic [NrCores-1:0]             cfg_mask_i,
    input  logic [NrCores-1:0]             arr_valid_i,
    input  logic [NrCores*IdWidth-1:0]     arr_id_i,
    output logic [NrCores-1:0]             arr_ready_o,
    output logic [NrBarriers*GenWidth-1:0] gen_o,
    output logic [NrBarriers-1:0]          busy_o,
    output logic                           err_o,
    output logic [CoreWidth-1:0]           err_core_o
);

    logic [NrCores-1:0]   mask_r     [NrBarriers];
    logic [NrCores-1:0]   match_s    [NrBarriers];
    logic [NrCores-1:0]   release_s  [NrBarriers];
    logic [NrCores-1:0]   arrived_s  [NrBarriers];
    logic [NrCores-1:0]   sel_mask_s [NrCores];
    logic [IdWidth-1:0]   core_id_s  [NrCores];
    logic [NrBarriers-1:0] idle_s;
    logic [NrCores-1:0]   recorded_s, release_any_s, err_vec_s, arr_ready_r;
    logic [CoreWidth-1:0] err_core_r;
    logic                 err_r, cfg_ready_s;

    function automatic logic [CoreWidth-1:0] lowest_index(input logic [NrCores-1:0] vec);
        logic [CoreWidth-1:0] idx;
        idx = '0;
        for (int i = NrCores - 1; i >= 0; i--) begin
            idx = vec[i] ? CoreWidth'(i) : idx;
        end
        return idx;
    endfunction

    for (genvar i = 0; i < NrCores; i++) begin : g_core_id
        assign core_id_s[i] = arr_id_i[i*IdWidth +: IdWidth];
    end

    // Id decode: per-channel match vectors and the mask of each core's target channel.
    // An out-of-range id matches no channel, so its selected mask stays empty.
    always_comb begin
        for (int b = 0; b < NrBarriers; b++) begin
            match_s[b] = '0;
        end
        for (int i = 0; i < NrCores; i++) begin
            sel_mask_s[i] = '0;
            for (int b = 0; b < NrBarriers; b++) begin
                match_s[b][i] = arr_valid_i[i] && (core_id_s[i] == IdWidth'(b));
                sel_mask_s[i] = sel_mask_s[i] | ((core_id_s[i] == IdWidth'(b)) ? mask_r[b] : '0);
            end
        end
    end

    // Combine channel views and flag misuse by cores that are neither waiting nor being released.
    always_comb begin
        recorded_s    = '0;
        release_any_s = '0;
        cfg_ready_s   = 1'b0;
        for (int b = 0; b < NrBarriers; b++) begin
            recorded_s    = recorded_s | arrived_s[b];
            release_any_s = release_any_s | release_s[b];
            cfg_ready_s   = cfg_ready_s | ((cfg_id_i == IdWidth'(b)) && idle_s[b]);
        end
        for (int i = 0; i < NrCores; i++) begin
            err_vec_s[i] = arr_valid_i[i] && !sel_mask_s[i][i] && !recorded_s[i] && !arr_ready_r[i];
        end
    end

    // Release and error pulses, one cycle after the deciding sample.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            arr_ready_r <= '0;
            err_r       <= 1'b0;
            err_core_r  <= '0;
        end else begin
            arr_ready_r <= release_any_s | err_vec_s;
            err_r       <= |err_vec_s;
            err_core_r  <= lowest_index(err_vec_s);
        end
    end

    // Participant masks; channel 0 defaults to the whole cluster.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int b = 0; b < NrBarriers; b++) begin
                mask_r[b] <= (b == 0) ? {NrCores{1'b1}} : {NrCores{1'b0}};
            end
        end else begin
            for (int b = 0; b < NrBarriers; b++) begin
                if (cfg_valid_i && cfg_ready_s && (cfg_id_i == IdWidth'(b))) begin
                    mask_r[b] <= cfg_mask_i;
                end else begin
                    mask_r[b] <= mask_r[b];
                end
            end
        end
    end

    for (genvar b = 0; b < NrBarriers; b++) begin : g_channel
        snitch_barrier_channel #(
            .NrCores  (NrCores),
            .GenWidth (GenWidth)
        ) u_channel (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .match_i   (match_s[b]),
            .mask_i    (mask_r[b]),
            .release_o (release_s[b]),
            .arrived_o (arrived_s[b]),
            .idle_o    (idle_s[b]),
            .busy_o    (busy_o[b]),
            .gen_o     (gen_o[b*GenWidth +: GenWidth])
        );
    end

    assign cfg_ready_o = cfg_ready_s;
    assign arr_ready_o = arr_ready_r;
    assign err_o       = err_r;
    assign err_core_o  = err_core_r;

endmodule

// File: tb/tb_snitch_barrier_multi.sv
// Directed bench for snitch_barrier_multi: vector table plus hand-written multi-cycle sequences.
module tb_snitch_barrier_multi;

    localparam int NC = 8;
    localparam int NB = 4;
    localparam int GW = 2;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [IW-1:0]    cfg_id = '0;
    logic [NC-1:0]    cfg_mask = '0;
    logic [NC-1:0]    arr_valid = '0;
    logic [NC*IW-1:0] arr_id = '0;
    logic [NC-1:0]    arr_ready;
    logic [NB*GW-1:0] gen;
    logic [NB-1:0]    busy;
    logic             err;
    logic [2:0]       err_core;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  valid;
        logic [15:0] id;
        logic        cv;
        logic [1:0]  cid;
        logic [7:0]  cmask;
        logic        exp_cfg_ready;
        logic [7:0]  exp_ready;
        logic        exp_err;
        logic [2:0]  exp_core;
        logic [3:0]  exp_busy;
        logic [7:0]  exp_gen;
    } vec_t;

    vec_t vecs [21];
    int   gen_seq [5] = '{1, 2, 3, 0, 1};

    snitch_barrier_multi #(
        .NrCores    (NC),
        .NrBarriers (NB),
        .GenWidth   (GW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_id_i    (cfg_id),
        .cfg_mask_i  (cfg_mask),
        .arr_valid_i (arr_valid),
        .arr_id_i    (arr_id),
        .arr_ready_o (arr_ready),
        .gen_o       (gen),
        .busy_o      (busy),
        .err_o       (err),
        .err_core_o  (err_core)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    initial begin
        // valid, id, cfg_valid, cfg_id, cfg_mask, cfg_ready, ready, err, core, busy, gen
        vecs[0]  = '{8'h00, 16'h0000, 1'b1, 2'd1, 8'h0F, 1'b1, 8'h00, 1'b0, 3'd0, 4'h0, 8'h01};
        vecs[1]  = '{8'h00, 16'h0000, 1'b1, 2'd2, 8'hF0, 1'b1, 8'h00, 1'b0, 3'd0, 4'h0, 8'h01};
        vecs[2]  = '{8'hFF, 16'hAA55, 1'b0, 2'd0, 8'h00, 1'b1, 8'hFF, 1'b0, 3'd0, 4'h0, 8'h15};
        vecs[3]  = '{8'h00, 16'h0000, 1'b0, 2'd1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 4'h0, 8'h15};
        vecs[4]  = '{8'h20, 16'h0400, 1'b0, 2'd1, 8'h00, 1'b1, 8'h20, 1'b1, 3'd5, 4'h0, 8'h15};
        vecs[5]  = '{8'h00, 16'h0000, 1'b0, 2'd1, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 4'h0, 8'h15};
        vecs[6]  = '{8'h07, 16'h0015, 1'b0, 2'd1, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 4'h2, 8'h15};
        vecs[7]  = '{8'h07, 16'h0015, 1'b1, 2'd1, 8'h03, 1'b0, 8'h00, 1'b0, 3'd0, 4'h2, 8'h15};
        vecs[8]  = '{8'h0F, 16'h0055, 1'b1, 2'd1, 8'h03, 1'b0, 8'h0F, 1'b0, 3'd0, 4'h0, 8'h19};
        vecs[9]  = '{8'h00, 16'h0000, 1'b1, 2'd1, 8'h03, 1'b0, 8'h00, 1'b0, 3'd0, 4'h0, 8'h19};
        vecs[10] = '{8'h00, 16'h0000, 1'b1, 2'd1, 8'h03, 1'b1, 8'h00, 1'b0, 3'd0, 4'h0, 8'h19};
        vecs[11] = '{8'h04, 16'h0010, 1'b0, 2'd1, 8'h00, 1'b1, 8'h04, 1'b1, 3'd2, 4'h0, 8'h19};
        vecs[12] = '{8'h00, 16'h0000, 1'b0, 2'd1, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 4'h0, 8'h19};
        vecs[13] = '{8'h40, 16'h3000, 1'b0, 2'd1, 8'h00, 1'b1, 8'h40, 1'b1, 3'd6, 4'h0, 8'h19};
        vecs[14] = '{8'h90, 16'hC100, 1'b0, 2'd1, 8'h00, 1'b1, 8'h90, 1'b1, 3'd4, 4'h0, 8'h19};
        vecs[15] = '{8'h00, 16'h0000, 1'b0, 2'd3, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 4'h0, 8'h19};
        vecs[16] = '{8'h00, 16'h0000, 1'b1, 2'd3, 8'h80, 1'b1, 8'h00, 1'b0, 3'd0, 4'h0, 8'h19};
        vecs[17] = '{8'h80, 16'hC000, 1'b0, 2'd3, 8'h00, 1'b1, 8'h80, 1'b0, 3'd0, 4'h0, 8'h59};
        vecs[18] = '{8'h80, 16'hC000, 1'b0, 2'd3, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 4'h0, 8'h59};
        vecs[19] = '{8'h80, 16'hC000, 1'b0, 2'd3, 8'h00, 1'b1, 8'h80, 1'b0, 3'd0, 4'h0, 8'h99};
        vecs[20] = '{8'h00, 16'h0000, 1'b0, 2'd3, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 4'h0, 8'h99};

        // Reset state.
        tick();
        tick();
        check("rst_ready", 32'(arr_ready), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_err_core", 32'(err_core), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_gen", 32'(gen), 32'h0);
        rst = 1'b0;

        // Full-cluster barrier on channel 0, cores arriving every third cycle.
        for (int c = 0; c < 24; c++) begin
            arr_valid = arr_valid & ~arr_ready;
            if ((c % 3 == 0) && (c / 3 < NC)) arr_valid[c/3] = 1'b1;
            tick();
            check($sformatf("full_c%0d_ready", c), 32'(arr_ready), (c == 21) ? 32'hFF : 32'h0);
            check($sformatf("full_c%0d_err", c), 32'(err), 32'h0);
            if (c == 10) check("full_busy_mid", 32'(busy), 32'h1);
        end
        check("full_gen0", 32'(gen), 32'h01);

        // Table: split channels, misuse errors, blocked config, single-core latency.
        for (int r = 0; r < 21; r++) begin
            arr_valid = vecs[r].valid;
            arr_id    = vecs[r].id;
            cfg_valid = vecs[r].cv;
            cfg_id    = vecs[r].cid;
            cfg_mask  = vecs[r].cmask;
            #1;
            check($sformatf("row%0d_cfg_ready", r), 32'(cfg_ready), 32'(vecs[r].exp_cfg_ready));
            tick();
            check($sformatf("row%0d_ready", r), 32'(arr_ready), 32'(vecs[r].exp_ready));
            check($sformatf("row%0d_err", r), 32'(err), 32'(vecs[r].exp_err));
            if (vecs[r].exp_err) check($sformatf("row%0d_err_core", r), 32'(err_core), 32'(vecs[r].exp_core));
            check($sformatf("row%0d_busy", r), 32'(busy), 32'(vecs[r].exp_busy));
            check($sformatf("row%0d_gen", r), 32'(gen), 32'(vecs[r].exp_gen));
        end
        cfg_valid = 1'b0;
        arr_valid = '0;
        arr_id    = '0;

        // Reset in the middle of a partially collected barrier.
        arr_valid = 8'h0F;
        tick();
        check("mid_busy", 32'(busy), 32'h1);
        check("mid_ready", 32'(arr_ready), 32'h0);
        rst       = 1'b1;
        arr_valid = '0;
        tick();
        rst = 1'b0;
        check("mid_rst_ready", 32'(arr_ready), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_gen", 32'(gen), 32'h0);
        tick();
        check("mid_post_ready", 32'(arr_ready), 32'h0);

        // Channel 1 mask is empty again after reset.
        arr_valid = 8'h01;
        arr_id    = 16'h0001;
        tick();
        check("mask1_rst_err", 32'(err), 32'h1);
        check("mask1_rst_core", 32'(err_core), 32'h0);
        check("mask1_rst_ready", 32'(arr_ready), 32'h01);
        arr_valid = '0;
        arr_id    = '0;
        tick();

        // Five full barriers on channel 0: 2-bit generation counter wraps.
        for (int n = 0; n < 5; n++) begin
            arr_valid = 8'hFF;
            tick();
            check($sformatf("wrap%0d_ready", n), 32'(arr_ready), 32'hFF);
            check($sformatf("wrap%0d_err", n), 32'(err), 32'h0);
            arr_valid = '0;
            tick();
            check($sformatf("wrap%0d_gen", n), 32'(gen[GW-1:0]), 32'(gen_seq[n]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
